axi4_lite_rd_pipe: RTL and testbench
====================================

Name: axi4_lite_rd_pipe

Overview:
Parametrised AXI4-Lite read master with multiple outstanding reads. Successor to the single-shot read master: decoupled address (AR) and data (R) channels, in-order tag return through an internal tag FIFO, a registered response stage and a response watchdog. Sits between user logic (register-access engines, DMA descriptor fetch) and any AXI4-Lite slave or interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (32 or 64)
TAG_W, 4, user tag width returned with each response
MAX_OUT, 4, maximum outstanding reads; tag FIFO depth (>=1, power of two)
TIMEOUT_CYC, 1024, watchdog limit in cycles; 0 disables watchdog

Ports:
clk  in  1  clock, all logic on rising edge
arst  in  1  asynchronous active-high reset
req_addr  in  ADDR_W  read address
req_tag  in  TAG_W  user tag
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
rsp_data  out  DATA_W  read data
rsp_resp  out  2  AXI RRESP of this read
rsp_tag  out  TAG_W  tag of the matching request
rsp_valid  out  1  response valid
rsp_ready  in  1  user consumes response
m_axi_araddr  out  ADDR_W  AR address
m_axi_arprot  out  3  constant 3'b000
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rdata  in  DATA_W  R data
m_axi_rresp  in  2  R response
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
outstanding  out  clog2(MAX_OUT)+1  reads accepted but not yet returned on R
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (arst high, async): arvalid=0, araddr=0, rsp_valid=0, rsp_data/resp/tag=0, outstanding=0, FIFO empty, watchdog=0, timeout_err=0. Reset mid-operation abandons all in-flight reads; no responses are produced for them.
- req_ready = (!m_axi_arvalid || m_axi_arready) && (outstanding < MAX_OUT). No credit taken from a same-cycle R handshake.
- Accept (req_valid&&req_ready): next cycle araddr<=req_addr, arvalid<=1; req_tag pushed into tag FIFO; outstanding+1.
- AR: araddr/arvalid held stable until arready. On arready with no new accept, arvalid<=0. Back-to-back accepts give one AR per cycle when arready is held high.
- m_axi_rready = (!rsp_valid || rsp_ready) && (outstanding != 0). A stray R beat with outstanding==0 is never accepted.
- R handshake: next cycle rsp_data<=rdata, rsp_resp<=rresp, rsp_tag<=FIFO head (popped), rsp_valid<=1; outstanding-1. Latency R handshake -> rsp_valid: 1 cycle. Full throughput of 1 response/cycle while rsp_ready=1.
- rsp_valid clears on rsp_ready unless a new R handshake reloads the register in the same cycle.
- Simultaneous accept and R handshake: outstanding unchanged; FIFO push and pop both performed.
- Responses return in request order (single ID); rresp passed through unaltered, errors do not stop the pipe.
- Watchdog: counter increments each cycle outstanding!=0 and no R handshake; clears on R handshake or outstanding==0. When it reaches TIMEOUT_CYC (nonzero), timeout_err<=1, sticky until reset; counter saturates. Transactions continue normally afterwards.
- FIFO cannot overflow/underflow given the outstanding bound; no error flags needed for it.

Test Plan:
- Single read: req addr=0x10 tag=3, arready=1, slave returns 0xDEADBEEF OKAY 2 cycles later -> rsp_valid 1 cycle after R handshake, data=0xDEADBEEF, resp=0, tag=3; outstanding 1->0.
- Burst of 6 requests tags 0..5, slave withholds R -> exactly 4 AR issued, req_ready=0 with outstanding=4; releasing R returns tags 0..5 in order.
- Backpressure: rsp_ready=0 after first response -> rready=0, rsp_data held stable; rsp_ready=1 resumes with no loss or duplication.
- arready held low 5 cycles -> araddr/arvalid stable, req_ready=0; arready=1 -> next request accepted same cycle.
- SLVERR response (rresp=2) for tag 7 -> rsp_resp=2, tag=7; following reads OKAY.
- TIMEOUT_CYC=16, one read outstanding with no R -> timeout_err rises after 16 cycles, stays high after late R; arst asserted mid-read clears all outputs immediately.

Source files
------------

// File: rtl/axi4_lite_rd_pipe.sv
// AXI4-Lite read master with up to MAX_OUT reads in flight, in-order tag return,
// a registered response stage and a sticky response watchdog.
module axi4_lite_rd_pipe #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 4,
    parameter int MAX_OUT     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [TAG_W-1:0]           req_tag,
    input  logic                       req_valid,
    output logic                       req_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [1:0]                 rsp_resp,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ADDR_W-1:0]          m_axi_araddr,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [DATA_W-1:0]          m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       timeout_err
);

    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int WW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [OW-1:0] OUT_LIMIT = OW'(MAX_OUT);
    localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_OUT - 1);
    localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYC);
    localparam logic [WW-1:0] WD_LAST   = (TIMEOUT_CYC > 0) ? WW'(TIMEOUT_CYC - 1) : '0;

    logic [TAG_W-1:0] tag_mem [MAX_OUT];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WW-1:0]    wd_cnt;
    logic             accept;
    logic             r_hs;
    logic             wd_run;

    // A same-cycle R handshake does not free a credit for the request side.
    assign req_ready    = (!m_axi_arvalid || m_axi_arready) && (outstanding < OUT_LIMIT);
    assign m_axi_rready = (!rsp_valid || rsp_ready) && (outstanding != '0);
    assign m_axi_arprot = 3'b000;
    assign accept       = req_valid && req_ready;
    assign r_hs         = m_axi_rvalid && m_axi_rready;
    assign wd_run       = (outstanding != '0) && !r_hs;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
        end else if (accept) begin
            m_axi_araddr  <= req_addr;
            m_axi_arvalid <= 1'b1;
        end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (accept && !r_hs) begin
                outstanding <= outstanding + 1'b1;
            end else if (!accept && r_hs) begin
                outstanding <= outstanding - 1'b1;
            end
            if (accept) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (r_hs) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= req_tag;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rsp_data  <= '0;
            rsp_resp  <= '0;
            rsp_tag   <= '0;
            rsp_valid <= 1'b0;
        end else if (r_hs) begin
            rsp_data  <= m_axi_rdata;
            rsp_resp  <= m_axi_rresp;
            rsp_tag   <= tag_mem[rd_ptr];
            rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Counter saturates at the limit; with TIMEOUT_CYC == 0 it never leaves zero.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!wd_run) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if ((TIMEOUT_CYC > 0) && wd_run && (wd_cnt == WD_LAST)) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_rd_pipe.sv
// Self-checking bench for axi4_lite_rd_pipe: a cycle table for single reads,
// then hand-written burst, backpressure, AR stall, watchdog and reset sequences.
module tb_axi4_lite_rd_pipe;

    logic        clk;
    logic        arst;
    logic [31:0] req_addr;
    logic [3:0]  req_tag;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [3:0]  rsp_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [2:0]  outstanding;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    axi4_lite_rd_pipe #(
        .ADDR_W(32), .DATA_W(32), .TAG_W(4), .MAX_OUT(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .arst(arst),
        .req_addr(req_addr), .req_tag(req_tag), .req_valid(req_valid), .req_ready(req_ready),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_tag(rsp_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .outstanding(outstanding), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] addr;
        logic [3:0]  tag;
        logic        ar;
        logic        rvld;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rsprdy;
        logic        e_rr;
        logic        e_av;
        logic [31:0] e_aa;
        logic        e_rd;
        logic        e_sv;
        logic [31:0] e_d;
        logic [1:0]  e_r;
        logic [3:0]  e_t;
        logic [2:0]  e_o;
    } vec_t;

    vec_t vecs[17];

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid     = v.rv;
        req_addr      = v.addr;
        req_tag       = v.tag;
        m_axi_arready = v.ar;
        m_axi_rvalid  = v.rvld;
        m_axi_rdata   = v.rdata;
        m_axi_rresp   = v.rresp;
        rsp_ready     = v.rsprdy;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string s;
        s = $sformatf("vec%0d", idx);
        checkVal({s, " req_ready"}, 64'(req_ready), 64'(v.e_rr));
        checkVal({s, " arvalid"}, 64'(m_axi_arvalid), 64'(v.e_av));
        checkVal({s, " araddr"}, 64'(m_axi_araddr), 64'(v.e_aa));
        checkVal({s, " rready"}, 64'(m_axi_rready), 64'(v.e_rd));
        checkVal({s, " rsp_valid"}, 64'(rsp_valid), 64'(v.e_sv));
        checkVal({s, " rsp_data"}, 64'(rsp_data), 64'(v.e_d));
        checkVal({s, " rsp_resp"}, 64'(rsp_resp), 64'(v.e_r));
        checkVal({s, " rsp_tag"}, 64'(rsp_tag), 64'(v.e_t));
        checkVal({s, " outstanding"}, 64'(outstanding), 64'(v.e_o));
        checkVal({s, " arprot"}, 64'(m_axi_arprot), 64'd0);
    endtask

    task automatic idleInputs();
        req_valid     = 1'b0;
        req_addr      = '0;
        req_tag       = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = '0;
        rsp_ready     = 1'b1;
    endtask

    initial begin
        int next_req, ar_cnt, r_beats, got, served;
        logic        stall_seen;
        logic [31:0] stall_data;
        logic [3:0]  exp_tag;

        arst = 1'b1;
        idleInputs();
        repeat (2) @(negedge clk);
        arst = 1'b0;

        //           rv addr     tag ar rvld rdata         rr rdy | rr av aa      rd sv data          r  t  o
        vecs[0]  = '{0, 32'h00, 0, 0, 0, 32'h0,        0, 1,  1, 0, 32'h00, 0, 0, 32'h0,        0, 0, 0};
        vecs[1]  = '{1, 32'h10, 3, 1, 0, 32'h0,        0, 1,  1, 0, 32'h00, 0, 0, 32'h0,        0, 0, 0};
        vecs[2]  = '{0, 32'h00, 0, 1, 0, 32'h0,        0, 1,  1, 1, 32'h10, 1, 0, 32'h0,        0, 0, 1};
        vecs[3]  = '{0, 32'h00, 0, 0, 0, 32'h0,        0, 1,  1, 0, 32'h10, 1, 0, 32'h0,        0, 0, 1};
        vecs[4]  = '{0, 32'h00, 0, 0, 1, 32'hDEADBEEF, 0, 1,  1, 0, 32'h10, 1, 0, 32'h0,        0, 0, 1};
        vecs[5]  = '{0, 32'h00, 0, 0, 0, 32'h0,        0, 1,  1, 0, 32'h10, 0, 1, 32'hDEADBEEF, 0, 3, 0};
        vecs[6]  = '{0, 32'h00, 0, 0, 0, 32'h0,        0, 1,  1, 0, 32'h10, 0, 0, 32'hDEADBEEF, 0, 3, 0};
        vecs[7]  = '{1, 32'h20, 7, 1, 0, 32'h0,        0, 1,  1, 0, 32'h10, 0, 0, 32'hDEADBEEF, 0, 3, 0};
        vecs[8]  = '{0, 32'h00, 0, 1, 0, 32'h0,        0, 1,  1, 1, 32'h20, 1, 0, 32'hDEADBEEF, 0, 3, 1};
        vecs[9]  = '{0, 32'h00, 0, 0, 1, 32'h0BAD0BAD, 2, 1,  1, 0, 32'h20, 1, 0, 32'hDEADBEEF, 0, 3, 1};
        vecs[10] = '{1, 32'h30, 1, 0, 0, 32'h0,        0, 1,  1, 0, 32'h20, 0, 1, 32'h0BAD0BAD, 2, 7, 0};
        vecs[11] = '{0, 32'h00, 0, 1, 0, 32'h0,        0, 1,  1, 1, 32'h30, 1, 0, 32'h0BAD0BAD, 2, 7, 1};
        vecs[12] = '{1, 32'h40, 2, 0, 1, 32'h12345678, 0, 1,  1, 0, 32'h30, 1, 0, 32'h0BAD0BAD, 2, 7, 1};
        vecs[13] = '{0, 32'h00, 0, 0, 0, 32'h0,        0, 1,  0, 1, 32'h40, 1, 1, 32'h12345678, 0, 1, 1};
        vecs[14] = '{0, 32'h00, 0, 1, 0, 32'h0,        0, 1,  1, 1, 32'h40, 1, 0, 32'h12345678, 0, 1, 1};
        vecs[15] = '{0, 32'h00, 0, 0, 1, 32'hCAFEF00D, 0, 1,  1, 0, 32'h40, 1, 0, 32'h12345678, 0, 1, 1};
        vecs[16] = '{0, 32'h00, 0, 0, 0, 32'h0,        0, 1,  1, 0, 32'h40, 0, 1, 32'hCAFEF00D, 0, 2, 0};

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
            @(negedge clk);
        end

        // Burst of six with R withheld: only four may be accepted and issued.
        idleInputs();
        next_req = 0;
        ar_cnt   = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid     = (next_req < 6);
            req_tag       = 4'(next_req);
            req_addr      = 32'h100 + 32'(4 * next_req);
            m_axi_arready = 1'b1;
            #1;
            if (m_axi_arvalid && m_axi_arready) begin
                checkVal("burst araddr", 64'(m_axi_araddr), 64'(32'h100 + 32'(4 * ar_cnt)));
                ar_cnt++;
            end
            if (req_valid && req_ready) next_req++;
            @(negedge clk);
        end
        #1;
        checkVal("burst accepted", 64'(next_req), 64'd4);
        checkVal("burst ar issued", 64'(ar_cnt), 64'd4);
        checkVal("burst outstanding", 64'(outstanding), 64'd4);
        checkVal("burst req_ready full", 64'(req_ready), 64'd0);
        @(negedge clk);

        // Release R with a stall window on the user side; tags must come back 0..5 once each.
        r_beats    = 0;
        got        = 0;
        stall_seen = 1'b0;
        stall_data = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            req_valid     = (next_req < 6);
            req_tag       = 4'(next_req);
            req_addr      = 32'h100 + 32'(4 * next_req);
            m_axi_arready = 1'b1;
            m_axi_rvalid  = (ar_cnt > r_beats);
            m_axi_rdata   = 32'hA0000000 + 32'(r_beats);
            m_axi_rresp   = 2'b00;
            rsp_ready     = !(c >= 2 && c < 6);
            #1;
            if (rsp_valid) begin
                if (rsp_ready) begin
                    checkVal("order tag", 64'(rsp_tag), 64'(got));
                    checkVal("order data", 64'(rsp_data), 64'(32'hA0000000 + 32'(got)));
                    got++;
                    stall_seen = 1'b0;
                end else begin
                    checkVal("stall rready", 64'(m_axi_rready), 64'd0);
                    if (stall_seen) checkVal("stall data held", 64'(rsp_data), 64'(stall_data));
                    stall_seen = 1'b1;
                    stall_data = rsp_data;
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                checkVal("release araddr", 64'(m_axi_araddr), 64'(32'h100 + 32'(4 * ar_cnt)));
                ar_cnt++;
            end
            if (m_axi_rvalid && m_axi_rready) r_beats++;
            if (req_valid && req_ready) next_req++;
            @(negedge clk);
        end
        idleInputs();
        checkVal("release responses", 64'(got), 64'd6);
        checkVal("release r beats", 64'(r_beats), 64'd6);
        checkVal("release ar total", 64'(ar_cnt), 64'd6);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkVal("no duplicate rsp", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        #1;
        checkVal("drained outstanding", 64'(outstanding), 64'd0);
        @(negedge clk);

        // AR stalled for five cycles: address held, no further accepts.
        req_valid = 1'b1; req_tag = 4'd9; req_addr = 32'h200; m_axi_arready = 1'b0;
        #1;
        checkVal("arstall first accept", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_tag = 4'd10; req_addr = 32'h204;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkVal("arstall arvalid", 64'(m_axi_arvalid), 64'd1);
            checkVal("arstall araddr", 64'(m_axi_araddr), 64'h200);
            checkVal("arstall req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        m_axi_arready = 1'b1;
        #1;
        checkVal("arready req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checkVal("second ar addr", 64'(m_axi_araddr), 64'h204);
        checkVal("second ar valid", 64'(m_axi_arvalid), 64'd1);
        @(negedge clk);
        m_axi_arready = 1'b0;
        served  = 0;
        got     = 0;
        exp_tag = 4'd9;
        for (int c = 0; c < 10 && got < 2; c++) begin
            m_axi_rvalid = (served < 2);
            m_axi_rdata  = 32'h5500 + 32'(served);
            #1;
            if (rsp_valid && rsp_ready) begin
                checkVal("arstall rsp tag", 64'(rsp_tag), 64'(exp_tag));
                exp_tag = exp_tag + 4'd1;
                got++;
            end
            if (m_axi_rvalid && m_axi_rready) served++;
            @(negedge clk);
        end
        checkVal("arstall responses", 64'(got), 64'd2);
        idleInputs();

        // Watchdog: one read with no R for more than 16 cycles.
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        #1;
        checkVal("wd reset err", 64'(timeout_err), 64'd0);
        req_valid = 1'b1; req_tag = 4'd5; req_addr = 32'h300; m_axi_arready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (13) @(negedge clk);
        #1;
        checkVal("wd early err", 64'(timeout_err), 64'd0);
        repeat (7) @(negedge clk);
        #1;
        checkVal("wd fired err", 64'(timeout_err), 64'd1);
        @(negedge clk);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h77; rsp_ready = 1'b0;
        #1;
        checkVal("late r rready", 64'(m_axi_rready), 64'd1);
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        #1;
        checkVal("late rsp_valid", 64'(rsp_valid), 64'd1);
        checkVal("late rsp_data", 64'(rsp_data), 64'h77);
        checkVal("late rsp_tag", 64'(rsp_tag), 64'd5);
        checkVal("wd sticky err", 64'(timeout_err), 64'd1);

        // Reset in the middle of a read clears everything at once.
        req_valid = 1'b1; req_tag = 4'd6; req_addr = 32'h400; m_axi_arready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checkVal("pre-reset arvalid", 64'(m_axi_arvalid), 64'd1);
        #1;
        arst = 1'b1;
        #1;
        checkVal("rst arvalid", 64'(m_axi_arvalid), 64'd0);
        checkVal("rst araddr", 64'(m_axi_araddr), 64'd0);
        checkVal("rst rsp_valid", 64'(rsp_valid), 64'd0);
        checkVal("rst rsp_data", 64'(rsp_data), 64'd0);
        checkVal("rst rsp_tag", 64'(rsp_tag), 64'd0);
        checkVal("rst outstanding", 64'(outstanding), 64'd0);
        checkVal("rst timeout_err", 64'(timeout_err), 64'd0);
        @(negedge clk);
        arst = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h99; rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkVal("stray rready", 64'(m_axi_rready), 64'd0);
            checkVal("stray rsp_valid", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        idleInputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
